// File: rtl/fifo_param.sv
// Parametrised first-word-fall-through token FIFO with occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_param #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_BITS = 2,
    parameter int AFULL_TH  = 3,
    parameter int AEMPTY_TH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] inData,
    input  logic                 write,
    input  logic                 read,
    output logic [DATA_SIZE-1:0] outData,
    output logic                 isFull,
    output logic                 isEmpty,
    output logic                 almostFull,
    output logic                 almostEmpty,
    output logic [ADDR_BITS:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int                 DEPTH     = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] ZERO_C    = {(ADDR_BITS+1){1'b0}};
    localparam logic [ADDR_BITS:0] ONE_C     = {{ADDR_BITS{1'b0}}, 1'b1};
    localparam logic [ADDR_BITS:0] DEPTH_C   = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0] AFULL_C   = (ADDR_BITS+1)'(AFULL_TH);
    localparam logic [ADDR_BITS:0] AEMPTY_C  = (ADDR_BITS+1)'(AEMPTY_TH);
    localparam logic [ADDR_BITS-1:0] PTR_ONE_C = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    // Flag helpers evaluated on an occupancy value; used for both reset and next-state.
    function automatic logic flag_full(input logic [ADDR_BITS:0] cnt);
        return (cnt == DEPTH_C);
    endfunction

    function automatic logic flag_empty(input logic [ADDR_BITS:0] cnt);
        return (cnt == ZERO_C);
    endfunction

    function automatic logic flag_afull(input logic [ADDR_BITS:0] cnt);
        return (cnt >= AFULL_C);
    endfunction

    function automatic logic flag_aempty(input logic [ADDR_BITS:0] cnt);
        return (cnt <= AEMPTY_C);
    endfunction

    logic [DATA_SIZE-1:0] regs_r [DEPTH];
    logic [ADDR_BITS-1:0] read_head_r;
    logic [ADDR_BITS-1:0] write_head_r;
    logic [ADDR_BITS:0]   count_r;
    logic [ADDR_BITS:0]   count_nxt_s;
    logic                 rd_ok_s;
    logic                 wr_ok_s;
    logic                 full_r;
    logic                 empty_r;
    logic                 afull_r;
    logic                 aempty_r;
    logic                 overflow_r;
    logic                 underflow_r;

    // Acceptance: reset drops everything; a full FIFO still takes a write when a read retires.
    always_comb begin
        rd_ok_s = 1'b0;
        wr_ok_s = 1'b0;
        if (rst) begin
            rd_ok_s = 1'b0;
            wr_ok_s = 1'b0;
        end else begin
            rd_ok_s = read && (count_r != ZERO_C);
            wr_ok_s = write && ((count_r != DEPTH_C) || rd_ok_s);
        end
    end

    // Next occupancy from the accepted operations.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_nxt_s = count_r + ONE_C;
            2'b01:   count_nxt_s = count_r - ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy, registered flags and sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_head_r  <= {ADDR_BITS{1'b0}};
            write_head_r <= {ADDR_BITS{1'b0}};
            count_r      <= ZERO_C;
            full_r       <= flag_full(ZERO_C);
            empty_r      <= flag_empty(ZERO_C);
            afull_r      <= flag_afull(ZERO_C);
            aempty_r     <= flag_aempty(ZERO_C);
            overflow_r   <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            if (rd_ok_s) begin
                read_head_r <= read_head_r + PTR_ONE_C;
            end
            if (wr_ok_s) begin
                write_head_r <= write_head_r + PTR_ONE_C;
            end
            count_r  <= count_nxt_s;
            full_r   <= flag_full(count_nxt_s);
            empty_r  <= flag_empty(count_nxt_s);
            afull_r  <= flag_afull(count_nxt_s);
            aempty_r <= flag_aempty(count_nxt_s);
            if (write && !wr_ok_s) begin
                overflow_r <= 1'b1;
            end
            if (read && !rd_ok_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    // Storage array is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            regs_r[write_head_r] <= inData;
        end
    end

    assign outData     = regs_r[read_head_r];
    assign count       = count_r;
    assign isFull      = full_r;
    assign isEmpty     = empty_r;
    assign almostFull  = afull_r;
    assign almostEmpty = aempty_r;
    assign overflow    = overflow_r;
    assign underflow   = underflow_r;

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fifo_param;

    localparam int DW = 8;
    localparam int AB = 2;
    localparam int DEPTH = 4;
    localparam int AFT = 3;
    localparam int AET = 1;

    logic          clk;
    logic          rst;
    logic [DW-1:0] inData;
    logic          write;
    logic          read;
    logic [DW-1:0] outData;
    logic          isFull;
    logic          isEmpty;
    logic          almostFull;
    logic          almostEmpty;
    logic [AB:0]   count;
    logic          overflow;
    logic          underflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] mq[$];
    bit m_ovf;
    bit m_unf;

    fifo_param #(.DATA_SIZE(DW), .ADDR_BITS(AB), .AFULL_TH(AFT), .AEMPTY_TH(AET)) dut (
        .clk(clk), .rst(rst), .inData(inData), .write(write), .read(read),
        .outData(outData), .isFull(isFull), .isEmpty(isEmpty),
        .almostFull(almostFull), .almostEmpty(almostEmpty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with the given inputs; the model follows the FIFO rules.
    task automatic drive(input logic rs, input logic w, input logic r, input logic [DW-1:0] d);
        bit rd_ok;
        bit wr_ok;
        rst = rs; write = w; read = r; inData = d;
        @(posedge clk);
        if (rs) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            rd_ok = r && (mq.size() != 0);
            wr_ok = w && ((mq.size() != DEPTH) || rd_ok);
            if (rd_ok) void'(mq.pop_front());
            if (wr_ok) mq.push_back(d);
            if (w && !wr_ok) m_ovf = 1'b1;
            if (r && !rd_ok) m_unf = 1'b1;
        end
        #1;
        rst = 1'b0; write = 1'b0; read = 1'b0; inData = 8'h00;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_cmp++; if (isEmpty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b expected 1", isEmpty); end
        n_cmp++; if (almostEmpty !== 1'b1) begin n_err++; $display("FAIL reset_aempty: got %b expected 1", almostEmpty); end
        n_cmp++; if (isFull !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b expected 0", isFull); end
        n_cmp++; if (almostFull !== 1'b0) begin n_err++; $display("FAIL reset_afull: got %b expected 0", almostFull); end
        n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL reset_err: got %b%b expected 00", overflow, underflow); end
    endtask

    task automatic test_fill();
        logic [DW-1:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, vals[i]);
            n_cmp++; if (count !== 3'(i + 1)) begin n_err++; $display("FAIL fill_count: got %0d expected %0d", count, i + 1); end
            n_cmp++; if (almostFull !== (i >= 2)) begin n_err++; $display("FAIL fill_afull: got %b expected %b", almostFull, (i >= 2)); end
            n_cmp++; if (isFull !== (i == 3)) begin n_err++; $display("FAIL fill_full: got %b expected %b", isFull, (i == 3)); end
            n_cmp++; if (outData !== 8'h11) begin n_err++; $display("FAIL fill_head: got %h expected 11", outData); end
            n_cmp++; if (almostEmpty !== (i == 0)) begin n_err++; $display("FAIL fill_aempty: got %b expected %b", almostEmpty, (i == 0)); end
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] exp_q [4];
        exp_q[0] = 8'h11; exp_q[1] = 8'h22; exp_q[2] = 8'h33; exp_q[3] = 8'h44;
        drive(1'b0, 1'b1, 1'b0, 8'h55);
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL ovf_count: got %0d expected 4", count); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (outData !== exp_q[i]) begin n_err++; $display("FAIL ovf_drain: got %h expected %h", outData, exp_q[i]); end
            drive(1'b0, 1'b0, 1'b1, 8'h00);
        end
        n_cmp++; if (isEmpty !== 1'b1) begin n_err++; $display("FAIL ovf_empty: got %b expected 1", isEmpty); end
        n_cmp++; if ({overflow, underflow} !== 2'b10) begin n_err++; $display("FAIL ovf_sticky: got %b%b expected 10", overflow, underflow); end
    endtask

    task automatic test_pass_through();
        logic [DW-1:0] exp_q [4];
        exp_q[0] = 8'h22; exp_q[1] = 8'h33; exp_q[2] = 8'h44; exp_q[3] = 8'h55;
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 8'h11);
        drive(1'b0, 1'b1, 1'b0, 8'h22);
        drive(1'b0, 1'b1, 1'b0, 8'h33);
        drive(1'b0, 1'b1, 1'b0, 8'h44);
        drive(1'b0, 1'b1, 1'b1, 8'h55);
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL pt_count: got %0d expected 4", count); end
        n_cmp++; if (isFull !== 1'b1) begin n_err++; $display("FAIL pt_full: got %b expected 1", isFull); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL pt_ovf: got %b expected 0", overflow); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (outData !== exp_q[i]) begin n_err++; $display("FAIL pt_drain: got %h expected %h", outData, exp_q[i]); end
            drive(1'b0, 1'b0, 1'b1, 8'h00);
        end
    endtask

    task automatic test_underflow();
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL unf_flag: got %b expected 1", underflow); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL unf_count: got %0d expected 0", count); end
        drive(1'b0, 1'b1, 1'b1, 8'h66);
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL unf_sim_count: got %0d expected 1", count); end
        n_cmp++; if (outData !== 8'h66) begin n_err++; $display("FAIL unf_sim_head: got %h expected 66", outData); end
        n_cmp++; if (isEmpty !== 1'b0) begin n_err++; $display("FAIL unf_sim_empty: got %b expected 0", isEmpty); end
        n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL unf_sticky: got %b expected 1", underflow); end
    endtask

    task automatic test_wrap_reset();
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'($urandom));
            n_cmp++; if (outData !== mq[0]) begin n_err++; $display("FAIL wrap_head_w: got %h expected %h", outData, mq[0]); end
            drive(1'b0, 1'b0, 1'b1, 8'h00);
            n_cmp++; if (outData !== mq[0]) begin n_err++; $display("FAIL wrap_head_r: got %h expected %h", outData, mq[0]); end
        end
        drive(1'b0, 1'b1, 1'b0, 8'hA5);
        n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL wrap_count: got %0d expected 2", count); end
        drive(1'b1, 1'b1, 1'b0, 8'h77);
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rstmid_count: got %0d expected 0", count); end
        n_cmp++; if (isEmpty !== 1'b1) begin n_err++; $display("FAIL rstmid_empty: got %b expected 1", isEmpty); end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rstmid_drop: got %0d expected 0", count); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom), 8'($urandom));
            n_cmp++; if (count !== 3'(mq.size())) begin n_err++; $display("FAIL rnd_count: got %0d expected %0d", count, mq.size()); end
            n_cmp++; if (isEmpty !== (mq.size() == 0)) begin n_err++; $display("FAIL rnd_empty: got %b expected %b", isEmpty, (mq.size() == 0)); end
            n_cmp++; if (isFull !== (mq.size() == DEPTH)) begin n_err++; $display("FAIL rnd_full: got %b expected %b", isFull, (mq.size() == DEPTH)); end
            n_cmp++; if (almostFull !== (mq.size() >= AFT)) begin n_err++; $display("FAIL rnd_afull: got %b expected %b", almostFull, (mq.size() >= AFT)); end
            n_cmp++; if (almostEmpty !== (mq.size() <= AET)) begin n_err++; $display("FAIL rnd_aempty: got %b expected %b", almostEmpty, (mq.size() <= AET)); end
            n_cmp++; if (overflow !== m_ovf) begin n_err++; $display("FAIL rnd_ovf: got %b expected %b", overflow, m_ovf); end
            n_cmp++; if (underflow !== m_unf) begin n_err++; $display("FAIL rnd_unf: got %b expected %b", underflow, m_unf); end
            if (mq.size() != 0) begin
                n_cmp++; if (outData !== mq[0]) begin n_err++; $display("FAIL rnd_head: got %h expected %h", outData, mq[0]); end
            end
        end
    endtask

    initial begin
        rst = 1'b0; write = 1'b0; read = 1'b0; inData = 8'h00;
        m_ovf = 1'b0; m_unf = 1'b0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_overflow();
        test_pass_through();
        test_underflow();
        test_wrap_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised first-word-fall-through FIFO for inter-PE token buffering in the CGRA fabric.
- Next-generation replacement for the fixed 4-entry token FIFO, with configurable depth and occupancy count.
- Adds almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a synchronous reset.
- Accepts a write while full if a read retires in the same cycle.

Parameters:
- DATA_SIZE, 8, token width in bits including the MSB tag bit.
- ADDR_BITS, 2, log2 of depth; DEPTH = 2**ADDR_BITS; legal range 1..8.
- AFULL_TH, 3, almostFull asserts when count >= AFULL_TH; legal range 1..DEPTH.
- AEMPTY_TH, 1, almostEmpty asserts when count <= AEMPTY_TH; legal range 0..DEPTH-1.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- inData  input  DATA_SIZE  write data.
- write  input  1  write request.
- read  input  1  read request; pops the head entry.
- outData  output  DATA_SIZE  head entry, valid whenever isEmpty=0 (FWFT); undefined when empty.
- isFull  output  1  count == DEPTH.
- isEmpty  output  1  count == 0.
- almostFull  output  1  count >= AFULL_TH.
- almostEmpty  output  1  count <= AEMPTY_TH.
- count  output  ADDR_BITS+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set by a rejected write.
- underflow  output  1  sticky; set by a rejected read.

Behaviour:
- All state updates on posedge clk; all flags are registered or derived only from registered count.
- Reset: while rst=1 at posedge, set readHead=writeHead=0, count=0, overflow=underflow=0.
  - rst has priority over read/write in that cycle; no data is written.
  - Resulting outputs: isEmpty=1, isFull=0, almostEmpty=1, almostFull=(AFULL_TH==0 ? 1 : 0), count=0.
  - Storage array contents are not reset.
- Read acceptance: rdOk = read && count!=0.
- Write acceptance: wrOk = write && (count!=DEPTH || rdOk).
  - New behaviour: a write to a full FIFO is accepted when a read is accepted in the same cycle.
- Empty with read and write together: the write is accepted and the read is rejected. There is no bypass, so the written token appears on outData the next cycle.
- On wrOk: regs[writeHead] <= inData; writeHead increments modulo DEPTH (natural wrap at ADDR_BITS width).
- On rdOk: readHead increments modulo DEPTH.
- Count update:
  - +1 on wrOk only.
  - -1 on rdOk only.
  - unchanged when both or neither are accepted.
- Latency: a write into an empty FIFO is visible on outData and clears isEmpty one cycle later.
- outData = regs[readHead] combinationally from the registered pointer.
- Sticky errors:
  - overflow <= 1 when write && !wrOk.
  - underflow <= 1 when read && !rdOk.
  - Both hold until rst.
  - The rejected operation has no other effect.
- Wrap-around: pointers wrap silently. count distinguishes full from empty when readHead==writeHead.
- Simulation trace (non-synthesised): $display with %m on each accepted read/write, printing data[DATA_SIZE-2:0].
- Reset mid-operation: all in-flight requests in the reset cycle are dropped. The first cycle after rst deasserts behaves as empty.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then rst=0 -> count=0, isEmpty=1, almostEmpty=1, isFull=0, overflow=underflow=0.
- Fill (DEPTH=4, AFULL_TH=3): write 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4; almostFull rises after the 3rd write; isFull after the 4th; outData=0x11 from the cycle after the first write.
- Overflow: full FIFO, write=1 read=0 with 0x55 -> count stays 4, overflow=1 next cycle; drain yields 0x11,0x22,0x33,0x44 and never 0x55.
- Full pass-through: full FIFO holding 0x11..0x44, read=1 write=1 with 0x55 -> count stays 4, isFull stays 1, outData becomes 0x22; full drain yields 0x22,0x33,0x44,0x55.
- Underflow/empty simultaneity: empty FIFO, read=1 -> underflow=1, count=0. Then read=1 write=1 with 0x66 -> count=1, outData=0x66 next cycle.
- Wrap and reset: 10 interleaved write/read pairs, checking FIFO order across pointer wrap. Then assert rst while count=2 with write=1 -> count=0, isEmpty=1, and the write is ignored.
